// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub datapath between two
// valid/ready requesters; one operation in flight, result held until accepted.
module addsub_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_sum,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_reg;
  logic             owner_reg;
  logic [WIDTH-1:0] op_a_reg, op_b_reg, sum_reg;
  logic             op_sub_reg;
  logic [CNT_W-1:0] count_reg;

  logic grant;
  logic accept;
  logic resp_hs;

  // On a tie the requester that was not served last wins.
  assign grant = req1_valid & (~req0_valid | ~last_reg);

  always_comb begin
    state_next  = state_reg;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    accept      = 1'b0;
    resp_hs     = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        accept     = req0_ready | req1_ready;
        if (accept) state_next = CALC;
      end
      CALC: state_next = RESP;
      RESP: begin
        resp0_valid = ~owner_reg;
        resp1_valid = owner_reg;
        resp_hs     = owner_reg ? resp1_ready : resp0_ready;
        if (resp_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      last_reg   <= 1'b1;
      owner_reg  <= 1'b0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_sub_reg <= 1'b0;
      sum_reg    <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        owner_reg  <= grant;
        op_a_reg   <= grant ? req1_a : req0_a;
        op_b_reg   <= grant ? req1_b : req0_b;
        op_sub_reg <= grant ? req1_sub : req0_sub;
      end
      if (state_reg == CALC) sum_reg <= alu_sum;
      if (resp_hs) begin
        last_reg  <= owner_reg;
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign alu_a    = op_a_reg;
  assign alu_b    = op_b_reg;
  assign alu_sub  = op_sub_reg;
  assign resp_sum = sum_reg;
  assign busy     = (state_reg != IDLE);
  assign op_count = count_reg;

endmodule
